wb_stage: RTL and testbench



---
 rtl/wb_pkg.sv | 37 +++
 rtl/ld_align.sv | 41 ++++
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types for the LA32 write-back stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int c_WB_DATA_W = 32;
  localparam int c_WB_REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_LOAD    = 2'b01,
    WB_PCPLUS4 = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_op_e;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            pc;
    logic                   rf_we;
    logic [c_WB_REG_AW-1:0] rd;
    logic [c_WB_DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/ld_align.sv
// ============================================================================
//  Module      : ld_align
//  Description : Extracts and sign/zero-extends load data from a cache word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ld_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       i_ld_data,
  input  logic [1:0]        i_offset,
  input  logic [2:0]        i_ld_op,
  output logic [DATA_W-1:0] o_ld_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_ld_data[{i_offset, 3'b000} +: 8];
    // Halfword offset bit 0 is ignored; misaligned accesses never reach here.
    w_half = i_offset[1] ? i_ld_data[31:16] : i_ld_data[15:0];
  end

  always_comb begin
    o_ld_result = DATA_W'($signed(i_ld_data));
    case (ld_op_e'(i_ld_op))
      LD_B:    o_ld_result = DATA_W'($signed(w_byte));
      LD_BU:   o_ld_result = DATA_W'(w_byte);
      LD_H:    o_ld_result = DATA_W'($signed(w_half));
      LD_HU:   o_ld_result = DATA_W'(w_half);
      default: o_ld_result = DATA_W'($signed(i_ld_data));
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : LA32 write-back stage: one-entry stage register, RF write
//                port, backpressured commit trace and retired counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_rf_we,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_ld_data,
  input  logic [2:0]        in_ld_op,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic [REG_AW-1:0] trace_rd,
  output logic [DATA_W-1:0] trace_wdata,
  output logic [63:0]       instret
);

  // The stage-register struct is sized from the package.
  if (DATA_W != c_WB_DATA_W || REG_AW != c_WB_REG_AW) begin : g_param_check
    $error("wb_stage: DATA_W/REG_AW must match wb_pkg entry widths");
  end

  wb_entry_t         entry_q, entry_d;
  logic [63:0]       instret_q, instret_d;

  logic              w_in_ready;
  logic              w_capture;
  logic              w_retire;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_ld_result;
  logic [DATA_W-1:0] w_wdata;

  ld_align #(
    .DATA_W (DATA_W)
  ) u_ld_align (
    .i_ld_data   (in_ld_data[31:0]),
    .i_offset    (in_alu_res[1:0]),
    .i_ld_op     (in_ld_op),
    .o_ld_result (w_ld_result)
  );

  assign w_in_ready = !entry_q.valid || trace_ready;
  assign w_capture  = in_valid && w_in_ready;
  assign w_retire   = entry_q.valid && trace_ready;
  assign w_wr_ok    = entry_q.rf_we && (entry_q.rd != '0);

  always_comb begin
    w_wdata = in_alu_res;
    case (wb_sel_e'(in_wb_sel))
      WB_LOAD:    w_wdata = w_ld_result;
      WB_PCPLUS4: w_wdata = DATA_W'(in_pc + 32'd4);
      default:    w_wdata = in_alu_res;
    endcase
  end

  always_comb begin
    entry_d   = entry_q;
    instret_d = instret_q;
    // A retiring entry may be replaced in the same cycle.
    if (w_capture) begin
      entry_d.valid = 1'b1;
      entry_d.pc    = in_pc;
      entry_d.rf_we = in_rf_we;
      entry_d.rd    = in_rd;
      entry_d.wdata = w_wdata;
    end else if (w_retire) begin
      entry_d.valid = 1'b0;
    end
    if (w_retire) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q   <= '0;
      instret_q <= '0;
    end else begin
      entry_q   <= entry_d;
      instret_q <= instret_d;
    end
  end

  assign in_ready    = w_in_ready;
  assign rf_we       = w_retire && w_wr_ok;
  assign rf_waddr    = entry_q.rd;
  assign rf_wdata    = entry_q.wdata;
  assign trace_valid = entry_q.valid;
  assign trace_pc    = entry_q.pc;
  assign trace_rd    = w_wr_ok ? entry_q.rd : '0;
  assign trace_wdata = entry_q.wdata;
  assign instret     = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage with a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic        in_rf_we = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_res = '0;
  logic [31:0] in_ld_data = '0;
  logic [2:0]  in_ld_op = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_wdata;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_rf_we    (in_rf_we),
    .in_rd       (in_rd),
    .in_wb_sel   (in_wb_sel),
    .in_alu_res  (in_alu_res),
    .in_ld_data  (in_ld_data),
    .in_ld_op    (in_ld_op),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_pc    (trace_pc),
    .trace_rd    (trace_rd),
    .trace_wdata (trace_wdata),
    .instret     (instret)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending commit records plus retired count.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        writes;
    logic [31:0] wdata;
  } rec_t;

  rec_t           pend[$];
  longint unsigned m_instret  = 0;
  int             n_accepted  = 0;
  int             n_writes    = 0;
  int             dut_we_cnt  = 0;

  function automatic logic [31:0] ref_wdata(input logic [1:0] sel, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [31:0] ld,
                                            input logic [2:0] op);
    longint s;
    int     off;
    off = int'(alu % 4);
    if (sel == 2'd2) begin
      s = (longint'(pc) + 4) % 64'h1_0000_0000;
      return s[31:0];
    end
    if (sel != 2'd1) return alu;
    case (op)
      3'b000, 3'b100: begin
        s = longint'(ld >> (8 * off)) % 256;
        if (op == 3'b000 && s >= 128) s = s - 256;
      end
      3'b001, 3'b101: begin
        s = longint'(ld >> (16 * (off / 2))) % 65536;
        if (op == 3'b001 && s >= 32768) s = s - 65536;
      end
      default: s = longint'(ld);
    endcase
    return s[31:0];
  endfunction

  // Compare outputs for the current state/inputs, then advance the model
  // to what the next rising edge will produce.
  task automatic check_cycle();
    bit   ev;
    bit   exp_we;
    rec_t r;
    ev     = (pend.size() != 0);
    exp_we = 1'b0;
    check_val("trace_valid", trace_valid, ev);
    check_val("in_ready", in_ready, !ev || trace_ready);
    if (ev) begin
      exp_we = trace_ready && pend[0].writes;
      check_val("trace_pc", trace_pc, pend[0].pc);
      check_val("trace_rd", trace_rd, pend[0].writes ? pend[0].rd : 5'd0);
      check_val("trace_wdata", trace_wdata, pend[0].wdata);
      check_val("rf_waddr", rf_waddr, pend[0].rd);
      check_val("rf_wdata", rf_wdata, pend[0].wdata);
    end
    check_val("rf_we", rf_we, exp_we);
    check_val("instret", instret, m_instret);
    if (rf_we) dut_we_cnt++;
    if (ev && trace_ready) begin
      void'(pend.pop_front());
      m_instret++;
    end
    if (in_valid && (!ev || trace_ready)) begin
      r.pc     = in_pc;
      r.rd     = in_rd;
      r.writes = in_rf_we && (in_rd != 5'd0);
      r.wdata  = ref_wdata(in_wb_sel, in_pc, in_alu_res, in_ld_data, in_ld_op);
      pend.push_back(r);
      n_accepted++;
      if (r.writes) n_writes++;
    end
  endtask

  task automatic tick(input logic iv, input logic [31:0] pc, input logic we, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] ld,
                      input logic [2:0] op, input logic tr);
    @(posedge clk);
    #1;
    in_valid    = iv;
    in_pc       = pc;
    in_rf_we    = we;
    in_rd       = rd;
    in_wb_sel   = sel;
    in_alu_res  = alu;
    in_ld_data  = ld;
    in_ld_op    = op;
    trace_ready = tr;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic rnd_tick(input logic iv, input logic tr);
    logic [4:0] rd;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    tick(iv, $urandom, 1'($urandom), rd, 2'($urandom), $urandom, $urandom, 3'($urandom), tr);
  endtask

  task automatic idle(input logic tr);
    rnd_tick(1'b0, tr);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_rf_we"}, rf_we, 0);
    check_val({pfx, "_rf_waddr"}, rf_waddr, 0);
    check_val({pfx, "_rf_wdata"}, rf_wdata, 0);
    check_val({pfx, "_trace_valid"}, trace_valid, 0);
    check_val({pfx, "_trace_pc"}, trace_pc, 0);
    check_val({pfx, "_trace_rd"}, trace_rd, 0);
    check_val({pfx, "_trace_wdata"}, trace_wdata, 0);
    check_val({pfx, "_instret"}, instret, 0);
    check_val({pfx, "_in_ready"}, in_ready, 1);
  endtask

  logic [2:0]  ld_ops  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ld_offs [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [31:0] ld_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    int cnt0;
    int acc0;
    int wr0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // ALU write
    tick(1'b1, 32'h0000_0100, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'd2, 1'b1);
    idle(1'b1);
    check_val("alu_rf_we", rf_we, 1);
    check_val("alu_waddr", rf_waddr, 5);
    check_val("alu_wdata", rf_wdata, 32'h1234_5678);
    check_val("alu_instret0", instret, 0);
    idle(1'b1);
    check_val("alu_instret1", instret, 1);

    // Load extension
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 32'h0000_0200 + 32'(4 * i), 1'b1, 5'd7, 2'b01, 32'h0000_1000 | 32'(ld_offs[i]),
           32'h80FF_7F01, ld_ops[i], 1'b1);
      idle(1'b1);
      check_val($sformatf("load_%0d", i), trace_wdata, ld_exp[i]);
    end

    // r0 suppression, then PC+4 wrap
    tick(1'b1, 32'h0000_0300, 1'b1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'd2, 1'b1);
    idle(1'b1);
    check_val("r0_rf_we", rf_we, 0);
    check_val("r0_trace_rd", trace_rd, 0);
    check_val("r0_trace_valid", trace_valid, 1);
    tick(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd9, 2'b10, 32'h5555_5555, 32'h0, 3'd2, 1'b1);
    check_val("r0_instret", instret, 7);
    idle(1'b1);
    check_val("pc4_wdata", trace_wdata, 32'h0);
    check_val("pc4_rf_we", rf_we, 1);

    // Backpressure
    tick(1'b1, 32'h0000_1000, 1'b1, 5'd3, 2'b00, 32'hAAAA_0001, 32'h0, 3'd2, 1'b1);
    cnt0 = dut_we_cnt;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 32'h0000_2000, 1'b1, 5'd4, 2'b00, 32'hBBBB_0002, 32'h0, 3'd2, 1'b0);
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_pc", trace_pc, 32'h0000_1000);
      check_val("bp_wdata", rf_wdata, 32'hAAAA_0001);
    end
    check_val("bp_no_write", dut_we_cnt - cnt0, 0);
    tick(1'b1, 32'h0000_2000, 1'b1, 5'd4, 2'b00, 32'hBBBB_0002, 32'h0, 3'd2, 1'b1);
    check_val("bp_release_we", rf_we, 1);
    check_val("bp_release_ready", in_ready, 1);
    check_val("bp_one_pulse", dut_we_cnt - cnt0, 1);
    idle(1'b1);
    check_val("bp_next_pc", trace_pc, 32'h0000_2000);
    check_val("bp_next_rd", rf_waddr, 4);

    // Reset while a valid entry is stalled
    tick(1'b1, 32'h0000_3000, 1'b1, 5'd11, 2'b00, 32'hCCCC_0003, 32'h0, 3'd2, 1'b0);
    idle(1'b0);
    check_val("rst_pre_valid", trace_valid, 1);
    idle(1'b0);
    cnt0 = dut_we_cnt;
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    pend.delete();
    m_instret = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    idle(1'b1);
    check_val("rst_post_instret", instret, 0);
    check_val("rst_no_write", dut_we_cnt - cnt0, 0);

    // Streaming with random backpressure
    acc0 = n_accepted;
    wr0  = n_writes;
    cnt0 = dut_we_cnt;
    for (int cyc = 0; cyc < 2000 && (n_accepted - acc0) < 100; cyc++) begin
      rnd_tick(1'b1, $urandom_range(0, 3) != 0);
    end
    for (int d = 0; d < 10; d++) idle(1'b1);
    check_val("stream_accepted", n_accepted - acc0, 100);
    check_val("stream_we_count", dut_we_cnt - cnt0, n_writes - wr0);
    check_val("stream_instret", instret, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got simulation time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
